// File: rtl/bip_tx_pkg.sv
// Shared types and constants for the BIP debug-path UART scheduler.
// State encoding, default character width and header tag.
package bip_tx_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = IDLE,
    S_START = START,
    S_WAIT  = WAIT
  } state_t;

  localparam int NB_BYTE_DEF = 8;

  localparam logic [3:0] HDR_TAG = 4'hA;

endpackage

// File: rtl/bip_rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr.
// The caller owns and advances the pointer.
module bip_rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PW-1:0]    idx,
  output logic             any
);

  always_comb begin
    int j;
    j     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      j = (int'(ptr) + i) % N_REQ;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = PW'(j);
      end
    end
  end

endmodule

// File: rtl/bip_tx_scheduler.sv
// Round-robin share of the BIP UART TX; words go out MSB byte first.
// Define BIP_TX_HEADER_EN to prefix each frame with {4'hA, winner}.
module bip_tx_scheduler
  import bip_tx_pkg::*;
#(
  parameter int NB_DATA = 16,
  parameter int N_REQ   = 3,
  parameter int NB_BYTE = NB_BYTE_DEF
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [N_REQ-1:0]         i_req_valid,
  input  logic [N_REQ*NB_DATA-1:0] i_req_data,
  output logic [N_REQ-1:0]         o_req_ready,
  output logic [N_REQ-1:0]         o_grant,
  output logic [NB_BYTE-1:0]       o_tx_data,
  output logic                     o_tx_start,
  input  logic                     i_tx_done,
  output logic                     o_busy
);

  localparam int PW = $clog2(N_REQ);
  localparam int NW = NB_DATA / 8;
`ifdef BIP_TX_HEADER_EN
  localparam int NBYTES = NW + 1;
  localparam int SW     = NB_DATA + 8;
`else
  localparam int NBYTES = NW;
  localparam int SW     = NB_DATA;
`endif
  localparam int CW = $clog2(NBYTES + 1);

  state_t             state, state_n;
  logic [PW-1:0]      rr_ptr, rr_ptr_n;
  logic [PW-1:0]      win, win_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [SW-1:0]      sh, sh_n;
  logic [N_REQ-1:0]   grant, grant_n;
  logic               done_d;
  logic               done_pos;
  logic [N_REQ-1:0]   arb_grant;
  logic [PW-1:0]      arb_idx;
  logic               arb_any;
  logic [NB_DATA-1:0] word;
  logic [SW-1:0]      load;

  bip_rr_arbiter #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_arb (
    .req   (i_req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign done_pos = i_tx_done & ~done_d;
  assign word = i_req_data[arb_idx*NB_DATA +: NB_DATA];

`ifdef BIP_TX_HEADER_EN
  assign load = {HDR_TAG, 4'(arb_idx), word};
`else
  assign load = word;
`endif

  always_comb begin
    state_n     = state;
    rr_ptr_n    = rr_ptr;
    win_n       = win;
    cnt_n       = cnt;
    sh_n        = sh;
    grant_n     = grant;
    o_req_ready = '0;
    o_tx_start  = 1'b0;
    unique case (state)
      S_IDLE: begin
        o_req_ready = arb_grant;
        if (arb_any) begin
          sh_n    = load;
          grant_n = arb_grant;
          win_n   = arb_idx;
          cnt_n   = CW'(NBYTES);
          state_n = S_START;
        end
      end
      S_START: begin
        o_tx_start = 1'b1;
        state_n    = S_WAIT;
      end
      S_WAIT: begin
        if (done_pos) begin
          cnt_n = cnt - 1'b1;
          if (cnt != CW'(1)) begin
            sh_n    = sh << NB_BYTE;
            state_n = S_START;
          end else begin
            grant_n  = '0;
            rr_ptr_n = (win == PW'(N_REQ - 1)) ?
                       '0 : win + 1'b1;
            state_n  = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // done_d resets high so a done held through reset is not an edge
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state  <= S_IDLE;
      rr_ptr <= '0;
      win    <= '0;
      cnt    <= '0;
      sh     <= '0;
      grant  <= '0;
      done_d <= 1'b1;
    end else begin
      state  <= state_n;
      rr_ptr <= rr_ptr_n;
      win    <= win_n;
      cnt    <= cnt_n;
      sh     <= sh_n;
      grant  <= grant_n;
      done_d <= i_tx_done;
    end
  end

  assign o_busy    = (state != S_IDLE);
  assign o_grant   = grant;
  assign o_tx_data = o_busy ? sh[SW-1 -: NB_BYTE] : '0;

endmodule

// File: tb/tb_bip_tx_scheduler.sv
// Randomized bench for bip_tx_scheduler against a frame-level model.
// Honors BIP_TX_HEADER_EN the same way the design does.
module tb_bip_tx_scheduler;

  localparam int NB_DATA = 16;
  localparam int N_REQ   = 3;
  localparam int NB_BYTE = 8;
  localparam int NW      = NB_DATA / 8;
  localparam int P_IDLE  = 0;
  localparam int P_START = 1;
  localparam int P_WAIT  = 2;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [N_REQ-1:0]         valid;
  logic [N_REQ*NB_DATA-1:0] data;
  logic [N_REQ-1:0]         ready;
  logic [N_REQ-1:0]         grant;
  logic [NB_BYTE-1:0]       tx_data;
  logic                     start;
  logic                     done;
  logic                     busy;

  always #5 clk = ~clk;

  bip_tx_scheduler #(
    .NB_DATA (NB_DATA),
    .N_REQ   (N_REQ),
    .NB_BYTE (NB_BYTE)
  ) dut (
    .i_clock     (clk),
    .i_reset     (rst_n),
    .i_req_valid (valid),
    .i_req_data  (data),
    .o_req_ready (ready),
    .o_grant     (grant),
    .o_tx_data   (tx_data),
    .o_tx_start  (start),
    .i_tx_done   (done),
    .o_busy      (busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  int m_phase, m_ptr, m_owner, cur_byte;
  int q[$];
  int order[$];
  int done_prev, resp_cnt, mode;
  logic [N_REQ-1:0] want, acc;
  bit one_shot, inj_idle, inj_start, hold_done;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N_REQ-1:0] v,
                              input int p);
    for (int i = 0; i < N_REQ; i++)
      if (v[(p + i) % N_REQ]) return (p + i) % N_REQ;
    return -1;
  endfunction

  task automatic drive();
    if (mode == 2) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (acc[k]) begin
          valid[k] = 1'($urandom_range(0, 1));
          data[k*NB_DATA +: NB_DATA] = NB_DATA'($urandom);
        end else if (!valid[k] && $urandom_range(0, 3) == 0) begin
          valid[k] = 1'b1;
          data[k*NB_DATA +: NB_DATA] = NB_DATA'($urandom);
        end else if ($urandom_range(0, 7) == 0) begin
          data[k*NB_DATA +: NB_DATA] = NB_DATA'($urandom);
        end
      end
    end else begin
      if (one_shot) want = want & ~acc;
      valid = want;
    end
    done = hold_done;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) done = 1'b1;
    end
    if (inj_idle && m_phase == P_IDLE) done = 1'b1;
    if (inj_start && m_phase == P_START) done = 1'b1;
  endtask

  task automatic check();
    int w;
    logic [N_REQ-1:0] er;
    logic [N_REQ-1:0] eg;
    bit pos;
    pos = done && (done_prev == 0);
    done_prev = int'(done);
    acc = '0;
    er = '0;
    eg = '0;
    w = (m_phase == P_IDLE) ? pick(valid, m_ptr) : -1;
    if (w >= 0) er[w] = 1'b1;
    if (m_phase != P_IDLE) eg[m_owner] = 1'b1;
    chk("ready", 64'(ready), 64'(er));
    chk("start", 64'(start), 64'(m_phase == P_START));
    chk("busy", 64'(busy), 64'(m_phase != P_IDLE));
    chk("grant", 64'(grant), 64'(eg));
    case (m_phase)
      P_IDLE: begin
        chk("data_idle", 64'(tx_data), 64'(0));
        if (w >= 0) begin
          m_owner = w;
          acc = er;
          order.push_back(w);
          q.delete();
`ifdef BIP_TX_HEADER_EN
          q.push_back(8'hA0 | w);
`endif
          for (int b = NW - 1; b >= 0; b--)
            q.push_back(int'(data[w*NB_DATA + b*8 +: 8]));
          m_phase = P_START;
        end
      end
      P_START: begin
        if (q.size() == 0) begin
          chk("byte_extra", 64'(1), 64'(0));
        end else begin
          cur_byte = q.pop_front();
          chk("byte", 64'(tx_data), 64'(cur_byte));
        end
        resp_cnt = $urandom_range(2, 5);
        m_phase = P_WAIT;
      end
      default: begin
        chk("data_hold", 64'(tx_data), 64'(cur_byte));
        if (pos) begin
          if (q.size() == 0) begin
            m_phase = P_IDLE;
            m_ptr = (m_owner + 1) % N_REQ;
          end else begin
            m_phase = P_START;
          end
        end
      end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    check();
  endtask

  task automatic run_idle(input int lim);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < lim; n++) begin
      step();
      if (m_phase == P_IDLE && valid == '0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("timeout_idle", 64'(0), 64'(1));
  endtask

  task automatic model_reset();
    m_phase = P_IDLE;
    m_ptr = 0;
    q.delete();
    resp_cnt = 0;
    done_prev = 1;
    acc = '0;
  endtask

  initial begin
    int base;
    bit ok;
    valid = '0;
    data = '0;
    done = 1'b1;
    mode = 0;
    want = '0;
    one_shot = 1'b0;
    hold_done = 1'b1;
    inj_idle = 1'b0;
    inj_start = 1'b0;
    model_reset();
    #12;
    chk("rst_ready", 64'(ready), 64'(0));
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_data", 64'(tx_data), 64'(0));
    chk("rst_start", 64'(start), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    rst_n = 1'b1;
    repeat (3) step();
    hold_done = 1'b0;
    repeat (2) step();

    data = 48'h0000_1234_0000;
    want = 3'b010;
    one_shot = 1'b1;
    run_idle(200);
    chk("single_owner", 64'(order[order.size()-1]), 64'(1));

    data[2*NB_DATA +: NB_DATA] = 16'h00FF;
    want = 3'b100;
    run_idle(200);

    inj_idle = 1'b1;
    step();
    inj_idle = 1'b0;
    step();

    data = 48'hCCCC_BBBB_AAAA;
    want = 3'b111;
    one_shot = 1'b0;
    base = order.size();
    ok = 1'b0;
    for (int n = 0; n < 600; n++) begin
      step();
      if (order.size() >= base + 6) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("timeout_rr", 64'(0), 64'(1));
    want = '0;
    run_idle(200);
    for (int i = 0; i < 6 && base + i < order.size(); i++)
      chk("rr_order", 64'(order[base+i]), 64'(i % 3));

    data[0 +: NB_DATA] = 16'h5A3C;
    want = 3'b001;
    inj_start = 1'b1;
    base = order.size();
    for (int n = 0; n < 400 && order.size() < base + 3; n++)
      step();
    want = '0;
    run_idle(200);
    inj_start = 1'b0;
    chk("b2b_frames", 64'(order.size() - base), 64'(3));

    data[NB_DATA +: NB_DATA] = 16'h9876;
    want = 3'b010;
    one_shot = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      step();
      if (m_phase == P_WAIT) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("timeout_wait", 64'(0), 64'(1));
    #2;
    want = '0;
    valid = '0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_grant", 64'(grant), 64'(0));
    chk("mid_rst_start", 64'(start), 64'(0));
    chk("mid_rst_data", 64'(tx_data), 64'(0));
    chk("mid_rst_ready", 64'(ready), 64'(0));
    model_reset();
    repeat (4) step();
    rst_n = 1'b1;
    repeat (3) step();

    data = 48'h1357_0000_2468;
    want = 3'b101;
    base = order.size();
    run_idle(400);
    if (order.size() > base)
      chk("post_rst_ptr", 64'(order[base]), 64'(0));
    else
      chk("post_rst_frame", 64'(0), 64'(1));

    mode = 2;
    repeat (800) step();
    mode = 0;
    want = '0;
    one_shot = 1'b0;
    run_idle(400);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
